// File: rtl/armleocpu_writeback.sv
// Writeback arbiter and long-latency scoreboard driving the regfile write port.
// Define ARMLEOCPU_WB_BYPASS_EN to clear pending bits at accept and forward the write stage.
module armleocpu_writeback (
  input  logic        clk,
  input  logic        rst,

  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,

  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rs1_fwd_valid,
  output logic        rs2_fwd_valid,
  output logic [31:0] rs1_fwd_data,
  output logic [31:0] rs2_fwd_data,

  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wdata,

  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_wdata,

  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wdata,

  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        rd_write
);

  typedef enum logic {RrLsu, RrMdu} rr_e;

  rr_e         rr_q, rr_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_wdata_q;
  logic        rd_write_q;

  logic        lsu_fire, mdu_fire, long_fire, issue_fire;
  logic        win_valid;
  logic [4:0]  win_rd;
  logic [31:0] win_wdata;

  // ALU wins outright; LSU/MDU share the leftover slot round-robin.
  always_comb begin
    lsu_ready = 1'b0;
    mdu_ready = 1'b0;
    if (!alu_valid) begin
      lsu_ready = lsu_valid && ((rr_q == RrLsu) || !mdu_valid);
      mdu_ready = mdu_valid && ((rr_q == RrMdu) || !lsu_valid);
    end
  end

  assign lsu_fire   = lsu_valid && lsu_ready;
  assign mdu_fire   = mdu_valid && mdu_ready;
  assign long_fire  = lsu_fire || mdu_fire;
  assign issue_fire = issue_valid && issue_ready;

  always_comb begin
    rr_d = rr_q;
    if (lsu_fire) begin
      rr_d = RrMdu;
    end else if (mdu_fire) begin
      rr_d = RrLsu;
    end
  end

  always_comb begin
    win_valid = 1'b0;
    win_rd    = 5'd0;
    win_wdata = 32'd0;
    if (alu_valid) begin
      win_valid = 1'b1;
      win_rd    = alu_rd;
      win_wdata = alu_wdata;
    end else if (lsu_fire) begin
      win_valid = 1'b1;
      win_rd    = lsu_rd;
      win_wdata = lsu_wdata;
    end else if (mdu_fire) begin
      win_valid = 1'b1;
      win_rd    = mdu_rd;
      win_wdata = mdu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= RrLsu;
      rd_addr_q  <= 5'd0;
      rd_wdata_q <= 32'd0;
      rd_write_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      if (win_valid) begin
        rd_addr_q  <= win_rd;
        rd_wdata_q <= win_wdata;
      end
      rd_write_q <= win_valid && (win_rd != 5'd0);
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_wdata = rd_wdata_q;
  assign rd_write = rd_write_q;

`ifdef ARMLEOCPU_WB_BYPASS_EN
  // Clear at the accept edge; the in-flight write is forwarded instead.
  always_comb begin
    pending_d = pending_q;
    if (issue_fire && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    if (long_fire) begin
      pending_d[win_rd] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  assign rs1_fwd_valid = rd_write_q && (rd_addr_q == rs1_addr) && (rs1_addr != 5'd0);
  assign rs2_fwd_valid = rd_write_q && (rd_addr_q == rs2_addr) && (rs2_addr != 5'd0);
  assign rs1_fwd_data  = rs1_fwd_valid ? rd_wdata_q : 32'd0;
  assign rs2_fwd_data  = rs2_fwd_valid ? rd_wdata_q : 32'd0;
`else
  logic       clr_valid_q;
  logic [4:0] clr_rd_q;

  // Delay the clear one edge so busy drops together with the regfile write.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_valid_q <= 1'b0;
      clr_rd_q    <= 5'd0;
    end else begin
      clr_valid_q <= long_fire && (win_rd != 5'd0);
      clr_rd_q    <= win_rd;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (issue_fire && (issue_rd != 5'd0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    if (clr_valid_q) begin
      pending_d[clr_rd_q] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = 32'd0;
  assign rs2_fwd_data  = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 32'd0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign issue_ready = !pending_q[issue_rd] || (issue_rd == 5'd0);
  assign rs1_busy    = pending_q[rs1_addr] && (rs1_addr != 5'd0);
  assign rs2_busy    = pending_q[rs2_addr] && (rs2_addr != 5'd0);

`ifndef SYNTHESIS
  a_alu_not_pending: assert property (@(posedge clk) disable iff (rst)
    (alu_valid && (alu_rd != 5'd0)) |-> !pending_q[alu_rd]);
  a_lsu_pending: assert property (@(posedge clk) disable iff (rst)
    (lsu_fire && (lsu_rd != 5'd0)) |-> pending_q[lsu_rd]);
  a_mdu_pending: assert property (@(posedge clk) disable iff (rst)
    (mdu_fire && (mdu_rd != 5'd0)) |-> pending_q[mdu_rd]);
`endif

endmodule

// File: tb/tb_armleocpu_writeback.sv
// Directed bench for armleocpu_writeback; expectations follow ARMLEOCPU_WB_BYPASS_EN.
module tb_armleocpu_writeback;

`ifdef ARMLEOCPU_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_wdata;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        rd_write;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  armleocpu_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_data  (rs2_fwd_data),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_wdata     (alu_wdata),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_wdata     (lsu_wdata),
    .mdu_valid     (mdu_valid),
    .mdu_ready     (mdu_ready),
    .mdu_rd        (mdu_rd),
    .mdu_wdata     (mdu_wdata),
    .rd_addr       (rd_addr),
    .rd_wdata      (rd_wdata),
    .rd_write      (rd_write)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    // Junk everywhere while reset is held.
    rst = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd3; rs2_addr = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wdata = 32'hFFFF_0000;
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_wdata = 32'h1234_5678;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_wdata = 32'h9ABC_DEF0;
    repeat (3) tick();
    check("rst_rd_write", rd_write, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_wdata", rd_wdata, 0);
    check("rst_rs1_busy", rs1_busy, 0);
    check("rst_rs2_busy", rs2_busy, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_rs1_fwd_valid", rs1_fwd_valid, 0);
    check("rst_rs2_fwd_data", rs2_fwd_data, 0);

    rst = 1'b0;
    issue_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;

    // ALU priority over a pending LSU result.
    issue(5'd6);
    issue_rd = 5'd6; rs1_addr = 5'd6; #1;
    check("prio_busy6", rs1_busy, 1);
    check("prio_issue_ready6", issue_ready, 0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_wdata = 32'h22; #1;
    check("prio_lsu_ready_blocked", lsu_ready, 0);
    tick();
    check("prio_alu_write", rd_write, 1);
    check("prio_alu_addr", rd_addr, 5);
    check("prio_alu_data", rd_wdata, 32'h11);
    alu_valid = 1'b0; #1;
    check("prio_lsu_ready", lsu_ready, 1);
    tick();
    check("prio_lsu_write", rd_write, 1);
    check("prio_lsu_addr", rd_addr, 6);
    check("prio_lsu_data", rd_wdata, 32'h22);
    lsu_valid = 1'b0; #1;
    check("prio_busy6_e0", rs1_busy, Byp ? 0 : 1);
    tick();
    check("prio_idle_write", rd_write, 0);
    check("prio_busy6_e1", rs1_busy, 0);

    // Round-robin: last grant was LSU, so MDU is preferred first.
    issue(5'd7);
    issue(5'd8);
    issue(5'd11);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'h77;
    mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_wdata = 32'h88; #1;
    check("rr1_lsu_ready", lsu_ready, 0);
    check("rr1_mdu_ready", mdu_ready, 1);
    tick();
    check("rr1_addr", rd_addr, 8);
    check("rr1_data", rd_wdata, 32'h88);
    mdu_rd = 5'd11; mdu_wdata = 32'hBB; #1;
    check("rr2_lsu_ready", lsu_ready, 1);
    check("rr2_mdu_ready", mdu_ready, 0);
    tick();
    check("rr2_addr", rd_addr, 7);
    check("rr2_data", rd_wdata, 32'h77);
    lsu_valid = 1'b0; rs1_addr = 5'd8; #1;
    check("rr_busy8_cleared", rs1_busy, 0);
    check("rr3_mdu_ready", mdu_ready, 1);
    tick();
    check("rr3_addr", rd_addr, 11);
    check("rr3_data", rd_wdata, 32'hBB);
    check("rr3_write", rd_write, 1);
    mdu_valid = 1'b0; rs1_addr = 5'd7; #1;
    check("rr_busy7_cleared", rs1_busy, 0);
    tick();
    check("rr_idle_write", rd_write, 0);

    // WAW stall on x9.
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    rs1_addr = 5'd9; #1;
    check("waw_issue_ready", issue_ready, 0);
    check("waw_busy9", rs1_busy, 1);
    tick();
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wdata = 32'h99; #1;
    check("waw_mdu_ready", mdu_ready, 1);
    check("waw_busy9_hold", rs1_busy, 1);
    tick();
    check("waw_addr", rd_addr, 9);
    mdu_valid = 1'b0; #1;
    check("waw_busy9_e0", rs1_busy, Byp ? 0 : 1);
    check("waw_ready_e0", issue_ready, Byp ? 1 : 0);
    tick();
    check("waw_busy9_e1", rs1_busy, 0);
    check("waw_ready_e1", issue_ready, 1);

    // x0 destination.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 32'hDEAD;
    issue_valid = 1'b1; issue_rd = 5'd0; #1;
    check("x0_issue_ready", issue_ready, 1);
    tick();
    check("x0_rd_write", rd_write, 0);
    check("x0_rd_addr", rd_addr, 0);
    alu_valid = 1'b0; issue_valid = 1'b0; rs1_addr = 5'd0; #1;
    check("x0_busy", rs1_busy, 0);
    check("x0_issue_ready_after", issue_ready, 1);

    // Bypass window on x10.
    issue(5'd10);
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_wdata = 32'hCAFE; rs2_addr = 5'd10; #1;
    check("byp_busy_before", rs2_busy, 1);
    tick();
    lsu_valid = 1'b0; #1;
    check("byp_rd_write", rd_write, 1);
    check("byp_fwd_valid", rs2_fwd_valid, Byp ? 1 : 0);
    check("byp_fwd_data", rs2_fwd_data, Byp ? 32'hCAFE : 0);
    check("byp_busy_e0", rs2_busy, Byp ? 0 : 1);
    check("byp_rs1_fwd_valid", rs1_fwd_valid, 0);
    tick();
    check("byp_busy_e1", rs2_busy, 0);
    check("byp_fwd_valid_e1", rs2_fwd_valid, 0);

    // Reset mid-operation drops pending bits and the captured write.
    issue(5'd12);
    rs1_addr = 5'd12; #1;
    check("mid_busy12", rs1_busy, 1);
    alu_valid = 1'b1; alu_rd = 5'd13; alu_wdata = 32'h5; rst = 1'b1;
    tick();
    rst = 1'b0; alu_valid = 1'b0; issue_rd = 5'd12; #1;
    check("mid_rd_write", rd_write, 0);
    check("mid_busy12_cleared", rs1_busy, 0);
    check("mid_issue_ready", issue_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
